// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage owning the PC, next-PC selection and the IF/ID register.
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   stall           hold PC and IF/ID
//   flush           squash IF/ID contents (insert bubble)
//   redirect_en     load redirect_pc (word aligned) into PC on the next edge
//   redirect_pc     redirect target address
//   PC              current fetch address to instrmem
//   instr           instruction returned by instrmem, combinational on PC
//   ifid_valid      IF/ID slot holds a real instruction
//   ifid_pc         PC of the IF/ID instruction
//   ifid_pc_plus4   ifid_pc + 4
//   ifid_instr      captured instruction (NOP_INSTR on bubble)
//   fetch_fault     one-cycle pulse: misaligned redirect or out-of-range captured PC
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 256,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic [31:0] PC,
    input  logic [31:0] instr,
    output logic        ifid_valid,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc_plus4,
    output logic [31:0] ifid_instr,
    output logic        fetch_fault
);
    typedef enum logic {BOOT, RUN} state_t;
    localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_WORDS);
    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_pc_plus4_q, ifid_pc_plus4_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic        fetch_fault_q, fetch_fault_d;
    logic [31:0] pc_plus4;
    logic        run, squash, capture;
    always_comb begin
        pc_plus4        = pc_q + 32'd4;
        run             = state_q == RUN;
        squash          = flush | redirect_en;
        capture         = run & ~squash & ~stall;
        state_d         = RUN;
        // redirect beats stall; the low address bits are dropped so PC stays aligned
        pc_d            = !run        ? pc_q :
                          redirect_en ? {redirect_pc[31:2], 2'b00} :
                          stall       ? pc_q : pc_plus4;
        ifid_valid_d    = capture ? 1'b1 : (run & squash) ? 1'b0 : ifid_valid_q;
        ifid_instr_d    = capture ? instr : (run & squash) ? NOP_INSTR : ifid_instr_q;
        ifid_pc_d       = capture ? pc_q : ifid_pc_q;
        ifid_pc_plus4_d = capture ? pc_plus4 : ifid_pc_plus4_q;
        // an out-of-range fetch is still passed downstream; only the pulse flags it
        fetch_fault_d   = run & ((redirect_en & |redirect_pc[1:0]) |
                                 (capture & ({2'b00, pc_q[31:2]} >= IMEM_LIMIT)));
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= BOOT;
            pc_q            <= RESET_PC;
            ifid_valid_q    <= 1'b0;
            ifid_pc_q       <= 32'd0;
            ifid_pc_plus4_q <= 32'd0;
            ifid_instr_q    <= NOP_INSTR;
            fetch_fault_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            ifid_valid_q    <= ifid_valid_d;
            ifid_pc_q       <= ifid_pc_d;
            ifid_pc_plus4_q <= ifid_pc_plus4_d;
            ifid_instr_q    <= ifid_instr_d;
            fetch_fault_q   <= fetch_fault_d;
        end
    end
    pc_aligned_a: assert property (@(posedge clk) disable iff (rst) pc_q[1:0] == 2'b00);
    assign PC            = pc_q;
    assign ifid_valid    = ifid_valid_q;
    assign ifid_pc       = ifid_pc_q;
    assign ifid_pc_plus4 = ifid_pc_plus4_q;
    assign ifid_instr    = ifid_instr_q;
    assign fetch_fault   = fetch_fault_q;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed-vector bench for fetch_stage with a PC-derived instruction memory.
module tb_fetch_stage;
    logic        clk, rst, stall, flush, redirect_en;
    logic [31:0] redirect_pc, PC, instr, ifid_pc, ifid_pc_plus4, ifid_instr;
    logic        ifid_valid, fetch_fault;
    int          checks = 0;
    int          errors = 0;

    fetch_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .redirect_en(redirect_en), .redirect_pc(redirect_pc), .PC(PC), .instr(instr),
        .ifid_valid(ifid_valid), .ifid_pc(ifid_pc), .ifid_pc_plus4(ifid_pc_plus4),
        .ifid_instr(ifid_instr), .fetch_fault(fetch_fault)
    );

    assign instr = 32'hC0DE_0000 ^ PC;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic s, input logic f, input logic r, input logic [31:0] rp);
        stall = s;
        flush = f;
        redirect_en = r;
        redirect_pc = rp;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 32'h0);
        repeat (2) @(negedge clk);
        chk("rst_pc", PC, 32'h0);
        chk("rst_valid", ifid_valid, 0);
        chk("rst_ifid_pc", ifid_pc, 32'h0);
        chk("rst_plus4", ifid_pc_plus4, 32'h0);
        chk("rst_instr", ifid_instr, 32'h13);
        chk("rst_fault", fetch_fault, 0);
        rst = 1'b0;
        step();
        chk("boot_pc", PC, 32'h0);
        chk("boot_valid", ifid_valid, 0);
        step();
        chk("run1_pc", PC, 32'h4);
        chk("run1_valid", ifid_valid, 1);
        chk("run1_ifid_pc", ifid_pc, 32'h0);
        chk("run1_plus4", ifid_pc_plus4, 32'h4);
        chk("run1_instr", ifid_instr, 32'hC0DE_0000);
        step();
        chk("run2_pc", PC, 32'h8);
        chk("run2_ifid_pc", ifid_pc, 32'h4);
        drive(1, 0, 0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc", PC, 32'h8);
            chk("stall_ifid_pc", ifid_pc, 32'h4);
            chk("stall_instr", ifid_instr, 32'hC0DE_0004);
        end
        drive(0, 0, 0, 32'h0);
        step();
        chk("resume_pc", PC, 32'hC);
        chk("resume_ifid_pc", ifid_pc, 32'h8);
        chk("resume_instr", ifid_instr, 32'hC0DE_0008);
        step();
        chk("pc_10", PC, 32'h10);
        drive(0, 0, 1, 32'h40);
        step();
        chk("redir_pc", PC, 32'h40);
        chk("redir_valid", ifid_valid, 0);
        chk("redir_instr", ifid_instr, 32'h13);
        chk("redir_ifid_pc_hold", ifid_pc, 32'hC);
        chk("redir_fault", fetch_fault, 0);
        drive(0, 0, 0, 32'h0);
        step();
        chk("post_redir_pc", PC, 32'h44);
        chk("post_redir_valid", ifid_valid, 1);
        chk("post_redir_ifid_pc", ifid_pc, 32'h40);
        chk("post_redir_instr", ifid_instr, 32'hC0DE_0040);
        drive(1, 0, 1, 32'h42);
        step();
        chk("mis_pc", PC, 32'h40);
        chk("mis_fault", fetch_fault, 1);
        chk("mis_valid", ifid_valid, 0);
        drive(0, 0, 0, 32'h0);
        step();
        chk("mis_fault_clr", fetch_fault, 0);
        chk("mis_next_pc", PC, 32'h44);
        chk("mis_ifid_pc", ifid_pc, 32'h40);
        drive(0, 0, 1, 32'h3FC);
        step();
        chk("edge_pc", PC, 32'h3FC);
        drive(0, 0, 0, 32'h0);
        step();
        chk("edge_pc_400", PC, 32'h400);
        chk("edge_ifid_3fc", ifid_pc, 32'h3FC);
        chk("edge_fault_in", fetch_fault, 0);
        step();
        chk("oor_ifid_pc", ifid_pc, 32'h400);
        chk("oor_fault", fetch_fault, 1);
        chk("oor_valid", ifid_valid, 1);
        chk("oor_instr", ifid_instr, 32'hC0DE_0400);
        drive(1, 1, 0, 32'h0);
        step();
        chk("fs_pc", PC, 32'h404);
        chk("fs_valid", ifid_valid, 0);
        chk("fs_instr", ifid_instr, 32'h13);
        chk("fs_ifid_pc", ifid_pc, 32'h400);
        chk("fs_fault", fetch_fault, 0);
        drive(0, 0, 1, 32'hFFFF_FFFC);
        step();
        chk("wrap_top", PC, 32'hFFFF_FFFC);
        drive(0, 0, 0, 32'h0);
        step();
        chk("wrap_pc", PC, 32'h0);
        chk("wrap_ifid_pc", ifid_pc, 32'hFFFF_FFFC);
        chk("wrap_plus4", ifid_pc_plus4, 32'h0);
        chk("wrap_fault", fetch_fault, 1);
        drive(0, 0, 1, 32'h20);
        step();
        chk("pre_rst_pc", PC, 32'h20);
        drive(0, 0, 0, 32'h0);
        rst = 1'b1;
        #1;
        chk("arst_pc", PC, 32'h0);
        chk("arst_valid", ifid_valid, 0);
        chk("arst_instr", ifid_instr, 32'h13);
        chk("arst_fault", fetch_fault, 0);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("reboot_pc", PC, 32'h0);
        chk("reboot_valid", ifid_valid, 0);
        step();
        chk("reboot_ifid_pc", ifid_pc, 32'h0);
        chk("reboot_valid1", ifid_valid, 1);
        chk("reboot_pc4", PC, 32'h4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
